// File: rtl/rfphoenix_dcache_tag_lookup_pkg.sv
// Shared constants, types and small helpers for the data-cache tag lookup block.
// Geometry defaults describe a 32-bit address, 64-byte lines and 64 sets of 4 ways.
package rfphoenix_dcache_tag_lookup_pkg;

    localparam int DC_ADRW  = 32;
    localparam int DC_LINEW = 6;
    localparam int DC_SETW  = 6;
    localparam int DC_TAGW  = DC_ADRW - DC_LINEW - DC_SETW;
    localparam int DC_WAYS  = 4;

    typedef logic [DC_TAGW-1:0] dc_tag_t;

    typedef enum logic {
        DCT_IDLE  = 1'b0,
        DCT_SWEEP = 1'b1
    } dc_tag_state_t;

    // Lowest-numbered matching way; 0 when nothing matches.
    function automatic logic [1:0] dc_first_way(input logic [DC_WAYS-1:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = DC_WAYS - 1; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic dc_multi(input logic [DC_WAYS-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < DC_WAYS; i++) begin
            if (m[i]) n++;
        end
        return (n > 1);
    endfunction

endpackage

// File: rtl/rfphoenix_dcache_tag_way.sv
// One cache way: per-set tag storage and valid vector with install, line
// invalidate, set clear and a write-first forwarded compare port.
module rfphoenix_dcache_tag_way #(
    parameter int SETW = 6,
    parameter int TAGW = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr,
    input  logic [SETW-1:0] wset,
    input  logic [TAGW-1:0] wtag,
    input  logic            inv,
    input  logic [SETW-1:0] iset,
    input  logic [TAGW-1:0] itag,
    input  logic            clr_set,
    input  logic [SETW-1:0] cset,
    input  logic [SETW-1:0] lset,
    input  logic [TAGW-1:0] ltag,
    output logic            match
);

    localparam int SETS = 1 << SETW;

    logic [TAGW-1:0] tags [SETS];
    logic [SETS-1:0] valid;
    logic            inv_hit;
    logic [TAGW-1:0] l_tag;
    logic            l_valid;

    // Invalidate compares against the stored tag, ignoring valid: clearing an
    // already-invalid entry is harmless.
    assign inv_hit = inv && (tags[iset] == itag);

    always_ff @(posedge clk) begin
        if (wr) tags[wset] <= wtag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clr_set) begin
            valid[cset] <= 1'b0;
        end else begin
            if (inv_hit) valid[iset] <= 1'b0;
            if (wr)      valid[wset] <= 1'b1;
        end
    end

    // The compare sees the state as it will be after this edge, so a lookup
    // issued alongside an install or invalidate observes its effect.
    always_comb begin
        l_tag   = tags[lset];
        l_valid = valid[lset];
        if (clr_set && (cset == lset)) l_valid = 1'b0;
        if (inv_hit && (iset == lset)) l_valid = 1'b0;
        if (wr && (wset == lset)) begin
            l_tag   = wtag;
            l_valid = 1'b1;
        end
        match = l_valid && (l_tag == ltag);
    end

endmodule

// File: rtl/rfphoenix_dcache_tag_lookup.sv
// 4-way tag/valid store with a one-cycle lookup pipeline, single-line
// invalidate and a whole-cache invalidate sweep.
module rfphoenix_dcache_tag_lookup
    import rfphoenix_dcache_tag_lookup_pkg::*;
#(
    parameter int ADRW  = DC_ADRW,
    parameter int LINEW = DC_LINEW,
    parameter int SETW  = DC_SETW,
    parameter int TAGW  = ADRW - LINEW - SETW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic [ADRW-1:0] adr,
    output logic            hit,
    output logic [1:0]      rway,
    output logic            multi_hit,
    input  logic            wr,
    input  logic [1:0]      wway,
    input  logic [ADRW-1:0] wadr,
    input  logic            inv_line,
    input  logic [ADRW-1:0] iadr,
    input  logic            inv_all,
    output logic            busy
);

    // Handshake: req, wr and inv_line are single-cycle strobes with no
    // backpressure. While busy is high, lookups return a miss and wr/inv_line
    // are dropped; the caller is expected to hold them off until busy falls.

    dc_tag_state_t        state;
    dc_tag_state_t        state_nx;
    logic [SETW-1:0]      cnt;
    logic                 sweep;
    logic                 wr_ok;
    logic                 inv_ok;
    logic                 look;
    logic [DC_WAYS-1:0]   match;

    logic [SETW-1:0]      l_set;
    logic [SETW-1:0]      w_set;
    logic [SETW-1:0]      i_set;
    logic [TAGW-1:0]      l_tag;
    logic [TAGW-1:0]      w_tag;
    logic [TAGW-1:0]      i_tag;
    logic                 unused_line_bits;

    assign l_set = adr[LINEW+:SETW];
    assign w_set = wadr[LINEW+:SETW];
    assign i_set = iadr[LINEW+:SETW];
    assign l_tag = adr[ADRW-1-:TAGW];
    assign w_tag = wadr[ADRW-1-:TAGW];
    assign i_tag = iadr[ADRW-1-:TAGW];

    assign unused_line_bits = ^{adr[LINEW-1:0], wadr[LINEW-1:0], iadr[LINEW-1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= DCT_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            DCT_IDLE:  if (inv_all) state_nx = DCT_SWEEP;
            DCT_SWEEP: if (&cnt)    state_nx = DCT_IDLE;
            default:                state_nx = DCT_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        sweep  = (state == DCT_SWEEP);
        busy   = sweep;
        wr_ok  = wr && !sweep;
        inv_ok = inv_line && !sweep;
        look   = req && !sweep;
    end

    // The counter wraps back to zero on the final sweep step.
    always_ff @(posedge clk) begin
        if (!rst_n)     cnt <= '0;
        else if (sweep) cnt <= cnt + 1'b1;
    end

    for (genvar w = 0; w < DC_WAYS; w++) begin : g_way
        rfphoenix_dcache_tag_way #(
            .SETW (SETW),
            .TAGW (TAGW)
        ) u_way (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (wr_ok && (wway == 2'(w))),
            .wset    (w_set),
            .wtag    (w_tag),
            .inv     (inv_ok),
            .iset    (i_set),
            .itag    (i_tag),
            .clr_set (sweep),
            .cset    (cnt),
            .lset    (l_set),
            .ltag    (l_tag),
            .match   (match[w])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit       <= 1'b0;
            rway      <= 2'd0;
            multi_hit <= 1'b0;
        end else begin
            hit       <= look && (|match);
            rway      <= look ? dc_first_way(match) : 2'd0;
            multi_hit <= multi_hit | (look && dc_multi(match));
        end
    end

endmodule

// File: tb/tb_rfphoenix_dcache_tag_lookup.sv
// Directed and randomized checks of the tag lookup block against a
// set/way array model of the cache contents.
module tb_rfphoenix_dcache_tag_lookup;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] adr;
    logic        hit;
    logic [1:0]  rway;
    logic        multi_hit;
    logic        wr;
    logic [1:0]  wway;
    logic [31:0] wadr;
    logic        inv_line;
    logic [31:0] iadr;
    logic        inv_all;
    logic        busy;

    always #5 clk = ~clk;

    rfphoenix_dcache_tag_lookup dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .adr       (adr),
        .hit       (hit),
        .rway      (rway),
        .multi_hit (multi_hit),
        .wr        (wr),
        .wway      (wway),
        .wadr      (wadr),
        .inv_line  (inv_line),
        .iadr      (iadr),
        .inv_all   (inv_all),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference contents: set = adr[11:6], tag = adr[31:12].
    bit        m_valid [64][4];
    bit [19:0] m_tag   [64][4];
    int        m_sweep_left = 0;
    bit        e_hit   = 1'b0;
    bit [1:0]  e_rway  = 2'd0;
    bit        e_multi = 1'b0;

    bit [19:0] fill_tag [4] = '{20'h11111, 20'h22222, 20'h33333, 20'h44444};
    bit [19:0] pool_tag [3] = '{20'h00AAA, 20'h00BBB, 20'h00CCC};
    bit [5:0]  pool_set [3] = '{6'd0, 6'd1, 6'd63};

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        req = 1'b0; adr = '0; wr = 1'b0; wway = 2'd0; wadr = '0;
        inv_line = 1'b0; iadr = '0; inv_all = 1'b0;
    endtask

    task automatic model_edge();
        bit busy_now;
        int nm;
        if (!rst_n) begin
            foreach (m_valid[s, w]) m_valid[s][w] = 1'b0;
            m_sweep_left = 0;
            e_hit = 1'b0; e_rway = 2'd0; e_multi = 1'b0;
        end else begin
            busy_now = (m_sweep_left > 0);
            if (busy_now) begin
                for (int w = 0; w < 4; w++) m_valid[64 - m_sweep_left][w] = 1'b0;
                m_sweep_left--;
            end else begin
                if (inv_line)
                    for (int w = 0; w < 4; w++)
                        if (m_tag[iadr[11:6]][w] == iadr[31:12]) m_valid[iadr[11:6]][w] = 1'b0;
                if (wr) begin
                    m_tag[wadr[11:6]][wway]   = wadr[31:12];
                    m_valid[wadr[11:6]][wway] = 1'b1;
                end
                if (inv_all) m_sweep_left = 64;
            end
            e_hit = 1'b0; e_rway = 2'd0;
            if (req && !busy_now) begin
                nm = 0;
                for (int w = 3; w >= 0; w--)
                    if (m_valid[adr[11:6]][w] && m_tag[adr[11:6]][w] == adr[31:12]) begin
                        nm++;
                        e_rway = 2'(w);
                    end
                e_hit = (nm > 0);
                if (nm > 1) e_multi = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("hit", hit, e_hit);
        check("rway", rway, e_rway);
        check("multi_hit", multi_hit, e_multi);
        check("busy", busy, m_sweep_left > 0);
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        check("rst_busy", busy, 0);

        // Lookup into an empty cache
        req = 1; adr = 32'h0000_1040; cycle();
        check("t1_hit", hit, 0); check("t1_rway", rway, 0); check("t1_busy", busy, 0);

        // Install then look up in the same line
        wr = 1; wway = 2; wadr = 32'h1234_5680; cycle();
        req = 1; adr = 32'h1234_56BC; cycle();
        check("t2_hit", hit, 1); check("t2_rway", rway, 2);

        // Install and lookup in the same cycle
        wr = 1; wway = 1; wadr = 32'hABCD_0000; req = 1; adr = 32'hABCD_0010; cycle();
        check("t3_hit", hit, 1); check("t3_rway", rway, 1); check("t3_multi", multi_hit, 0);

        // Duplicate tag in ways 0 and 3 of set 5
        wr = 1; wway = 0; wadr = 32'h5555_5140; cycle();
        wr = 1; wway = 3; wadr = 32'h5555_5140; cycle();
        req = 1; adr = 32'h5555_5150; cycle();
        check("t4_hit", hit, 1); check("t4_rway", rway, 0); check("t4_multi", multi_hit, 1);
        req = 1; adr = 32'h0000_1040; cycle();
        check("t4_sticky_hit", hit, 0); check("t4_sticky_multi", multi_hit, 1);

        // Fill set 0 and invalidate way 1
        for (int w = 0; w < 4; w++) begin
            wr = 1; wway = 2'(w); wadr = {fill_tag[w], 12'h000}; cycle();
        end
        inv_line = 1; iadr = {fill_tag[1], 12'h000}; cycle();
        for (int w = 0; w < 4; w++) begin
            req = 1; adr = {fill_tag[w], 12'h020}; cycle();
            check("t5_hit", hit, (w != 1));
            check("t5_rway", rway, (w != 1) ? w : 0);
        end

        // Full sweep with a lookup and a dropped install in the middle
        wr = 1; wway = 0; wadr = {20'h66666, 12'hFC0}; cycle();
        req = 1; adr = {20'h66666, 12'hFC0}; cycle();
        check("t6_pre_hit", hit, 1);
        inv_all = 1; cycle();
        check("t6_busy_start", busy, 1);
        for (int i = 0; i < 64; i++) begin
            if (i == 30) begin req = 1; adr = {fill_tag[0], 12'h000}; end
            if (i == 20) begin wr = 1; wway = 0; wadr = {20'h99999, 12'h000}; end
            if (i == 40) begin inv_all = 1; end
            cycle();
            check("t6_busy", busy, (i < 63));
            if (i == 30) check("t6_mid_hit", hit, 0);
        end
        req = 1; adr = {fill_tag[0], 12'h000}; cycle(); check("t6_set0_hit", hit, 0);
        req = 1; adr = {20'h66666, 12'hFC0}; cycle(); check("t6_set63_hit", hit, 0);
        req = 1; adr = {20'h99999, 12'h000}; cycle(); check("t6_dropped_wr", hit, 0);

        // Reset in the middle of a sweep
        wr = 1; wway = 0; wadr = {20'h77777, 12'h000}; cycle();
        wr = 1; wway = 2; wadr = {20'h77777, 12'h280}; cycle();
        inv_all = 1; cycle();
        for (int i = 0; i < 9; i++) cycle();
        check("t7_busy_before", busy, 1);
        rst_n = 1'b0; cycle();
        rst_n = 1'b1;
        check("t7_busy", busy, 0); check("t7_multi", multi_hit, 0);
        req = 1; adr = {20'h77777, 12'h000}; cycle(); check("t7_hit0", hit, 0);
        req = 1; adr = {20'h77777, 12'h280}; cycle(); check("t7_hit10", hit, 0);

        // Randomized traffic over a small pool of tags and sets
        for (int n = 0; n < 600; n++) begin
            req = ($urandom_range(0, 9) < 7);
            adr = {pool_tag[$urandom_range(0, 2)], pool_set[$urandom_range(0, 2)], 6'($urandom)};
            wr = ($urandom_range(0, 9) < 3);
            wway = 2'($urandom_range(0, 3));
            wadr = {pool_tag[$urandom_range(0, 2)], pool_set[$urandom_range(0, 2)], 6'($urandom)};
            inv_line = ($urandom_range(0, 9) == 0);
            iadr = {pool_tag[$urandom_range(0, 2)], pool_set[$urandom_range(0, 2)], 6'($urandom)};
            inv_all = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
